// File: rtl/clk_en_pkg.sv
// clk_en_gen shared constants and helpers.
// Channel-select width and divider half-period math.
package clk_en_pkg;

  localparam int DIV_OFF = 0;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [31:0] ceil_half(
    input logic [31:0] d
  );
    return (d >> 1) + {31'b0, d[0]};
  endfunction

endpackage

// File: rtl/clk_en_chan.sv
// One clock-enable channel: divisor, counter, pending
// divisor write, lock tracking and registered outputs.
module clk_en_chan
  import clk_en_pkg::*;
#(
  parameter int DIV_W        = 16,
  parameter int DEFAULT_DIV  = 0,
  parameter int LOCK_PERIODS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [DIV_W-1:0] wdiv,
  input  logic             sync,
  output logic             ce,
  output logic             div,
  output logic             lock,
  output logic             pend
);

  localparam int LW = $clog2(LOCK_PERIODS + 1);

  logic [DIV_W-1:0] d_act;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] pend_val;
  logic [DIV_W-1:0] cnt_nxt;
  logic [DIV_W-1:0] half;
  logic [LW-1:0]    lock_cnt;
  logic             ce_cnt;
  logic             started;
  logic             run;
  logic             wrap;
  logic             apply;

  assign run     = d_act != DIV_W'(DIV_OFF);
  assign wrap    = run && (cnt == d_act - DIV_W'(1));
  assign apply   = pend && (sync || !run || wrap);
  assign cnt_nxt = wrap ? '0 : cnt + DIV_W'(1);
  assign half    = DIV_W'(ceil_half(32'(d_act)));

  // ce_cnt marks pulses that count toward lock; the
  // pulse closing the old period at a switch does not.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d_act    <= DIV_W'(DEFAULT_DIV);
      cnt      <= '0;
      pend_val <= '0;
      pend     <= 1'b0;
      lock_cnt <= '0;
      ce       <= 1'b0;
      ce_cnt   <= 1'b0;
      div      <= 1'b0;
      lock     <= 1'b0;
      started  <= 1'b0;
    end else begin
      ce     <= 1'b0;
      ce_cnt <= 1'b0;
      if (apply) begin
        d_act    <= pend_val;
        cnt      <= '0;
        pend     <= 1'b0;
        lock_cnt <= '0;
        lock     <= 1'b0;
        if (run) begin
          ce      <= !sync || (pend_val != '0);
          div     <= pend_val != '0;
          started <= pend_val != '0;
        end else begin
          div     <= 1'b0;
          started <= 1'b0;
        end
      end else if (run) begin
        if (sync) begin
          cnt     <= '0;
          ce      <= 1'b1;
          ce_cnt  <= 1'b1;
          div     <= 1'b1;
          started <= 1'b1;
        end else begin
          cnt    <= cnt_nxt;
          ce     <= wrap;
          ce_cnt <= wrap;
          div    <= (started || wrap) && (cnt_nxt < half);
          if (wrap) started <= 1'b1;
        end
        if (ce_cnt && !lock) begin
          lock_cnt <= lock_cnt + LW'(1);
          if (lock_cnt == LW'(LOCK_PERIODS - 1))
            lock <= 1'b1;
        end
      end else begin
        div  <= 1'b0;
        lock <= 1'b0;
      end
      if (we) begin
        pend     <= 1'b1;
        pend_val <= wdiv;
      end
    end
  end

endmodule

// File: rtl/clk_en_gen.sv
// Multi-channel runtime-programmable clock-enable generator.
// Decodes divisor writes and broadcasts sync to each channel.
module clk_en_gen
  import clk_en_pkg::*;
#(
  parameter int CHANNELS     = 4,
  parameter int DIV_W        = 16,
  parameter int DEFAULT_DIV  = 0,
  parameter int LOCK_PERIODS = 4,
  parameter int CH_W         = ch_w(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [DIV_W-1:0]    cfg_div,
  input  logic                sync_i,
  output logic [CHANNELS-1:0] ce_o,
  output logic [CHANNELS-1:0] div_o,
  output logic [CHANNELS-1:0] lock_o,
  output logic [CHANNELS-1:0] pend_o
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic we;
    assign we = cfg_we && (cfg_ch == CH_W'(i));

    clk_en_chan #(
      .DIV_W        (DIV_W),
      .DEFAULT_DIV  (DEFAULT_DIV),
      .LOCK_PERIODS (LOCK_PERIODS)
    ) u_chan (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (we),
      .wdiv  (cfg_div),
      .sync  (sync_i),
      .ce    (ce_o[i]),
      .div   (div_o[i]),
      .lock  (lock_o[i]),
      .pend  (pend_o[i])
    );
  end

endmodule

// File: tb/tb_clk_en_gen.sv
// Directed bench for clk_en_gen with a queued scoreboard.
// Second instance covers DEFAULT_DIV=8 and out-of-range channel.
module tb_clk_en_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [15:0] cfg_div;
  logic        sync_i;
  logic [3:0]  ce_o, div_o, lock_o, pend_o;

  logic        cfg_we_b;
  logic [1:0]  cfg_ch_b;
  logic [15:0] cfg_div_b;
  logic        sync_b;
  logic [2:0]  ce_b, div_b, lock_b, pend_b;

  typedef struct {
    string      tag;
    int         sel;
    logic [3:0] mask;
    logic [3:0] val;
  } item_t;

  item_t q[$];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  clk_en_gen #(
    .CHANNELS(4), .DIV_W(16),
    .DEFAULT_DIV(0), .LOCK_PERIODS(4)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .sync_i(sync_i),
    .ce_o(ce_o), .div_o(div_o),
    .lock_o(lock_o), .pend_o(pend_o)
  );

  clk_en_gen #(
    .CHANNELS(3), .DIV_W(16),
    .DEFAULT_DIV(8), .LOCK_PERIODS(4)
  ) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we_b), .cfg_ch(cfg_ch_b),
    .cfg_div(cfg_div_b), .sync_i(sync_b),
    .ce_o(ce_b), .div_o(div_b),
    .lock_o(lock_b), .pend_o(pend_b)
  );

  function automatic logic [3:0] obs(input int sel);
    case (sel)
      0: return ce_o;
      1: return div_o;
      2: return lock_o;
      3: return pend_o;
      4: return {1'b0, ce_b};
      5: return {1'b0, div_b};
      6: return {1'b0, lock_b};
      7: return {1'b0, pend_b};
      default: return 4'hx;
    endcase
  endfunction

  task automatic want(input string tag, input int sel,
                      input logic [3:0] mask,
                      input logic [3:0] val);
    item_t it;
    it.tag = tag;
    it.sel = sel;
    it.mask = mask;
    it.val = val;
    q.push_back(it);
  endtask

  task automatic step();
    item_t it;
    logic [3:0] o;
    logic [3:0] e;
    @(posedge clk);
    #1;
    while (q.size() > 0) begin
      it = q.pop_front();
      o = obs(it.sel) & it.mask;
      e = it.val & it.mask;
      total++;
      assert (o === e) else begin
        bad++;
        $error("FAIL %s obs=%b exp=%b", it.tag, o, e);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; sync_i = 1'b0;
    cfg_we_b = 1'b0; cfg_ch_b = '0; cfg_div_b = '0;
    sync_b = 1'b0;

    for (int s = 0; s < 8; s++) want("reset", s, 4'hf, 4'h0);
    step();
    rst_n = 1'b1;

    // ch0 divisor 4 from disabled
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd4;
    want("a_pend_set", 3, 4'h1, 4'h1);
    step();
    cfg_we = 1'b0;
    want("a_pend_clr", 3, 4'h1, 4'h0);
    want("a_load_ce", 0, 4'h1, 4'h0);
    want("a_load_div", 1, 4'h1, 4'h0);
    step();
    for (int j = 1; j <= 20; j++) begin
      want("a_ce", 0, 4'h1, {3'b0, j % 4 == 0});
      want("a_div", 1, 4'h1,
           {3'b0, (j >= 4) && (j % 4 < 2)});
      want("a_lock", 2, 4'h1, {3'b0, j >= 17});
      want("a_pend", 3, 4'h1, 4'h0);
      step();
    end

    // ch1 divisor 5, then 1
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 16'd5;
    want("b_pend_set", 3, 4'h2, 4'h2);
    step();
    cfg_we = 1'b0;
    want("b_load_ce", 0, 4'h2, 4'h0);
    step();
    for (int k = 1; k <= 15; k++) begin
      want("b_ce", 0, 4'h2, {2'b0, k % 5 == 0, 1'b0});
      want("b_div", 1, 4'h2,
           {2'b0, (k >= 5) && (k % 5 < 3), 1'b0});
      step();
    end
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 16'd1;
    step();
    cfg_we = 1'b0;
    repeat (5) step();
    for (int k = 0; k < 6; k++) begin
      want("b1_ce", 0, 4'h2, 4'h2);
      want("b1_div", 1, 4'h2, 4'h2);
      step();
    end

    // ch2 divisor 6, switch to 3 mid-period
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_div = 16'd6;
    step();
    cfg_we = 1'b0;
    step();
    for (int k = 1; k <= 52; k++) begin
      cfg_we = (k == 33) || (k == 34);
      cfg_ch = 2'd2;
      cfg_div = (k == 33) ? 16'd9 : 16'd3;
      if (k <= 32) begin
        want("c_ce6", 0, 4'h4, {1'b0, k % 6 == 0, 2'b0});
        want("c_lock6", 2, 4'h4, {1'b0, k >= 25, 2'b0});
      end else begin
        want("c_ce", 0, 4'h4,
             {1'b0, (k >= 36) && ((k - 36) % 3 == 0), 2'b0});
        want("c_lock", 2, 4'h4,
             {1'b0, (k < 36) || (k >= 49), 2'b0});
        want("c_pend", 3, 4'h4, {1'b0, k < 36, 2'b0});
        want("c_div", 1, 4'h4,
             {1'b0, (k >= 36) && ((k - 36) % 3 != 2), 2'b0});
      end
      step();
    end
    cfg_we = 1'b0;

    // ch1 divisor 6 then global sync
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 16'd6;
    step();
    cfg_we = 1'b0;
    repeat (32) step();
    sync_i = 1'b1;
    want("d_sync_ce", 0, 4'hf, 4'h7);
    want("d_sync_div", 1, 4'hf, 4'h7);
    want("d_sync_lock", 2, 4'hf, 4'h7);
    step();
    sync_i = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      want("d_ce", 0, 4'hf,
           {1'b0, k % 3 == 0, k % 6 == 0, k % 4 == 0});
      want("d_lock", 2, 4'hf, 4'h7);
      step();
    end

    // ch3 running, then disabled by writing 0
    cfg_we = 1'b1; cfg_ch = 2'd3; cfg_div = 16'd5;
    step();
    cfg_we = 1'b0;
    want("e_load_ce", 0, 4'h8, 4'h0);
    step();
    for (int k = 1; k <= 40; k++) begin
      cfg_we = (k == 26);
      cfg_ch = 2'd3;
      cfg_div = 16'd0;
      want("e_ce", 0, 4'h8,
           {(k <= 30) && (k % 5 == 0), 3'b0});
      want("e_div", 1, 4'h8,
           {(k < 30) && (k >= 5) && (k % 5 < 3), 3'b0});
      want("e_lock", 2, 4'h8,
           {(k >= 21) && (k < 30), 3'b0});
      want("e_pend", 3, 4'h8,
           {(k >= 26) && (k < 30), 3'b0});
      step();
    end
    cfg_we = 1'b0;

    // reset mid-operation with a pending write
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd7;
    want("f_pend_set", 3, 4'h1, 4'h1);
    step();
    cfg_we = 1'b0;
    rst_n = 1'b0;
    for (int s = 0; s < 8; s++) want("f_reset", s, 4'hf, 4'h0);
    step();
    rst_n = 1'b1;
    for (int j = 1; j <= 40; j++) begin
      cfg_we_b = (j == 10);
      cfg_ch_b = 2'd3;
      cfg_div_b = 16'd2;
      if (j <= 12) begin
        want("f_ce", 0, 4'hf, 4'h0);
        want("f_div", 1, 4'hf, 4'h0);
        want("f_lock", 2, 4'hf, 4'h0);
        want("f_pend", 3, 4'hf, 4'h0);
      end
      want("g_ce", 4, 4'h7, {1'b0, {3{j % 8 == 0}}});
      want("g_div", 5, 4'h7,
           {1'b0, {3{(j >= 8) && (j % 8 < 4)}}});
      want("g_lock", 6, 4'h7, {1'b0, {3{j >= 33}}});
      want("g_pend", 7, 4'h7, 4'h0);
      step();
    end
    cfg_we_b = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
